// File: rtl/regfile_pkg.sv
// Shared register-file types and constants used by the write decoder,
// the read mux trees and the register file top level.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_write_decode_parts.sv
// Building blocks of the register file: the datapath 2:1 mux, a 32:1 tree
// made only of those muxes, and the 5-to-32 write-enable decoder.
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

module mux_tree32
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  reg_addr_t        i_sel,
    input  logic [WIDTH-1:0] i_leaf [0:NUM_REGS-1],
    output logic [WIDTH-1:0] o_y
);
    logic [WIDTH-1:0] w_l4 [0:15];
    logic [WIDTH-1:0] w_l3 [0:7];
    logic [WIDTH-1:0] w_l2 [0:3];
    logic [WIDTH-1:0] w_l1 [0:1];

    // Address bit 0 picks between neighbouring leaves; each higher bit halves the set.
    for (genvar j = 0; j < 16; j++) begin : g_l4
        mux2 #(.WIDTH(WIDTH)) u_mux (
            .i_sel(i_sel[0]), .i_a(i_leaf[2*j]), .i_b(i_leaf[2*j+1]), .o_y(w_l4[j])
        );
    end
    for (genvar j = 0; j < 8; j++) begin : g_l3
        mux2 #(.WIDTH(WIDTH)) u_mux (
            .i_sel(i_sel[1]), .i_a(w_l4[2*j]), .i_b(w_l4[2*j+1]), .o_y(w_l3[j])
        );
    end
    for (genvar j = 0; j < 4; j++) begin : g_l2
        mux2 #(.WIDTH(WIDTH)) u_mux (
            .i_sel(i_sel[2]), .i_a(w_l3[2*j]), .i_b(w_l3[2*j+1]), .o_y(w_l2[j])
        );
    end
    for (genvar j = 0; j < 2; j++) begin : g_l1
        mux2 #(.WIDTH(WIDTH)) u_mux (
            .i_sel(i_sel[3]), .i_a(w_l2[2*j]), .i_b(w_l2[2*j+1]), .o_y(w_l1[j])
        );
    end
    mux2 #(.WIDTH(WIDTH)) u_root (
        .i_sel(i_sel[4]), .i_a(w_l1[0]), .i_b(w_l1[1]), .o_y(o_y)
    );
endmodule

module decoder5_32
    import regfile_pkg::*;
(
    input  logic                i_en,
    input  reg_addr_t           i_addr,
    output logic [NUM_REGS-1:0] o_onehot
);
    logic [3:0] w_hi;
    logic [7:0] w_lo;

    // Gating the enable into the 2-to-4 stage keeps an unknown address harmless when disabled.
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        for (int k = 0; k < 4; k++) w_hi[k] = i_en & (i_addr[4:3] == 2'(k));
        for (int k = 0; k < 8; k++) w_lo[k] = (i_addr[2:0] == 3'(k));
    end

    always_comb begin
        o_onehot = '0;
        for (int n = 0; n < NUM_REGS; n++) o_onehot[n] = w_hi[n/8] & w_lo[n%8];
    end
endmodule

// File: rtl/reg_file_write_decode.sv
// 31 x WIDTH register file with a decoded single write port and two
// combinational read ports; index 31 is the hard-wired zero register.
module reg_file_write_decode
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = NUM_REGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWrite,
    input  reg_addr_t        WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  reg_addr_t        ReadRegister1,
    input  reg_addr_t        ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);
    logic [NREGS-1:0] w_dec;
    logic [NREGS-1:0] w_wen;
    logic [WIDTH-1:0] w_leaf [0:NREGS-1];

    decoder5_32 u_dec (
        .i_en    (RegWrite),
        .i_addr  (WriteRegister),
        .o_onehot(w_dec)
    );

    assign w_wen = w_dec & ~(NREGS'(1) << ZERO_REG);

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_reg
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_wen[i]) begin
                r_q <= WriteData;
            end
        end

        assign w_leaf[i] = r_q;
    end

    // The zero register's enable is forced low, so it doubles as the all-zero read leaf.
    assign w_leaf[ZERO_REG] = {WIDTH{w_wen[ZERO_REG]}};

    mux_tree32 #(.WIDTH(WIDTH)) u_rd1 (
        .i_sel (ReadRegister1),
        .i_leaf(w_leaf),
        .o_y   (ReadData1)
    );

    mux_tree32 #(.WIDTH(WIDTH)) u_rd2 (
        .i_sel (ReadRegister2),
        .i_leaf(w_leaf),
        .o_y   (ReadData2)
    );
endmodule

// File: tb/tb_reg_file_write_decode.sv
// Directed bench for reg_file_write_decode: reset, write/read sweep, zero
// register, write gating, same-address timing and asynchronous reset.
module tb_reg_file_write_decode;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int nAsserts = 0;
    int nFails   = 0;

    reg_file_write_decode #(.WIDTH(32), .NREGS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic readPair(input string tag, input logic [4:0] a1, input logic [31:0] e1,
                            input logic [4:0] a2, input logic [31:0] e2);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
        checkOutput({tag, "_rd1"}, ReadData1, e1);
        checkOutput({tag, "_rd2"}, ReadData2, e2);
    endtask

    task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
        RegWrite      = 1'b1;
        WriteRegister = a;
        WriteData     = d;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd1;
        logic [31:0] rnd2;

        rst_n         = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        repeat (2) @(posedge clk);
        #1;
        readPair("reset_state", 5'd0, 32'h0, 5'd30, 32'h0);
        rst_n = 1'b1;

        // Random writes followed by a three-cycle reset pulse
        rnd1 = $urandom;
        rnd2 = $urandom;
        applyStimulus(5'd1, rnd1);
        applyStimulus(5'd30, rnd2);
        readPair("random_write", 5'd1, rnd1, 5'd30, rnd2);
        rst_n = 1'b0;
        for (int a = 0; a < 32; a++) readPair("during_reset", 5'(a), 32'h0, 5'(31 - a), 32'h0);
        RegWrite = 1'b1;
        WriteRegister = 5'd1;
        WriteData = 32'hA5A5_A5A5;
        repeat (3) @(posedge clk);
        #1;
        RegWrite = 1'b0;
        readPair("reset_blocks_write", 5'd1, 32'h0, 5'd30, 32'h0);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) readPair("after_reset", 5'(a), 32'h0, 5'(31 - a), 32'h0);

        // Write every storage register; each read is old before the edge and new after
        for (int i = 0; i < 31; i++) begin
            RegWrite      = 1'b1;
            WriteRegister = 5'(i);
            WriteData     = 32'h1000_0000 + i;
            ReadRegister1 = 5'(i);
            #1;
            checkOutput("write_pre_edge", ReadData1, 32'h0);
            @(posedge clk);
            #1;
            checkOutput("write_post_edge", ReadData1, 32'h1000_0000 + i);
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 31; i++)
            readPair("pair_read", 5'(i), 32'h1000_0000 + i, 5'(30 - i), 32'h1000_0000 + (30 - i));

        // Writes to the zero register are dropped
        applyStimulus(5'd31, 32'hDEAD_BEEF);
        readPair("zero_reg", 5'd31, 32'h0, 5'd31, 32'h0);
        for (int i = 0; i < 31; i++) readPair("zero_reg_others", 5'(i), 32'h1000_0000 + i, 5'd31, 32'h0);

        // Disabled write and unknown address while disabled
        WriteRegister = 5'd5;
        WriteData     = 32'h0000_00FF;
        @(posedge clk);
        #1;
        readPair("write_disabled", 5'd5, 32'h1000_0005, 5'd4, 32'h1000_0004);
        WriteRegister = 5'bx;
        WriteData     = 32'h1234_5678;
        @(posedge clk);
        #1;
        for (int i = 0; i < 31; i++) readPair("x_addr_hold", 5'(i), 32'h1000_0000 + i, 5'd31, 32'h0);

        // Same-address read during write, both ports on the same register
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 32'h0000_0777;
        readPair("same_addr_pre", 5'd7, 32'h1000_0007, 5'd7, 32'h1000_0007);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        readPair("same_addr_post", 5'd7, 32'h0000_0777, 5'd7, 32'h0000_0777);

        // Back-to-back writes to one register
        RegWrite      = 1'b1;
        WriteRegister = 5'd8;
        WriteData     = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        readPair("b2b_first", 5'd8, 32'hCAFE_0001, 5'd9, 32'h1000_0009);
        WriteData = 32'hCAFE_0002;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        readPair("b2b_second", 5'd8, 32'hCAFE_0002, 5'd7, 32'h0000_0777);

        // Asynchronous reset half a cycle before a write edge
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 32'hFFFF_FFFF;
        rst_n         = 1'b0;
        readPair("async_reset_now", 5'd3, 32'h0, 5'd7, 32'h0);
        @(posedge clk);
        #1;
        readPair("async_reset_edge", 5'd3, 32'h0, 5'd8, 32'h0);
        RegWrite = 1'b0;
        rst_n    = 1'b1;
        applyStimulus(5'd3, 32'h0BAD_F00D);
        readPair("first_write_after_reset", 5'd3, 32'h0BAD_F00D, 5'd31, 32'h0);

        $display("[TB] directed sequence complete");
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
